// File: rtl/midi_rx_sequencer.sv
// midi_rx_sequencer
//   Receives the MIDI serial line (8N1, 31250 baud). It synchronizes the
//   line, detects start bits, samples each bit at its midpoint and assembles
//   bytes. It parses Note-On/Note-Off messages, including running status,
//   and presents them through a single-entry buffer with a valid/ready
//   handshake.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per MIDI bit. Must be at least 4. The start
//                  bit is re-sampled after CLKS_PER_BIT/2 cycles.
//
// Optional build macro
//   MIDI_CHAN_FILTER_EN : when this macro is defined, the chan_sel[3:0] input
//                         is added. Completed events on any other channel
//                         are discarded silently.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   usart      : MIDI serial data, idle high, asynchronous to clk
//   evt_valid  : an event is held in the output buffer
//   evt_ready  : the consumer accepts the event when this and evt_valid are high
//   chan_sel   : channel filter select (only with MIDI_CHAN_FILTER_EN)
//   evt_on     : 1 = note-on, 0 = note-off (a 0x9n event with velocity 0
//                is reported as off)
//   evt_chan   : MIDI channel
//   evt_note   : note number
//   evt_vel    : velocity
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   overrun    : one-cycle pulse when a completed event is dropped because
//                the buffer is full
//   busy       : high while the receive FSM is not idle
module midi_rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usart,
  output logic       evt_valid,
  input  logic       evt_ready,
`ifdef MIDI_CHAN_FILTER_EN
  input  logic [3:0] chan_sel,
`endif
  output logic       evt_on,
  output logic [3:0] evt_chan,
  output logic [6:0] evt_note,
  output logic [6:0] evt_vel,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_next;
  logic            r_sync1, r_sync2;
  logic            w_rx;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_half, w_full;
  logic            w_shift, w_stop_ok, w_stop_bad;

  logic            r_byte_done;
  logic [7:0]      r_byte;
  logic            r_frame_err;

  // Parser state
  logic            r_rs_valid;
  logic            r_rs_note;   // running status is 0x8n/0x9n
  logic            r_rs_on;     // status bit 4: 0x9n
  logic [3:0]      r_rs_chan;
  logic            r_rs_two;    // running message takes two data bytes
  logic            r_dcnt;
  logic [6:0]      r_note_lat;
  logic            w_chan_ok;

  logic            r_evt_done;
  logic            r_ev_on;
  logic [3:0]      r_ev_chan;
  logic [6:0]      r_ev_note;
  logic [6:0]      r_ev_vel;

  // Output buffer
  logic            r_valid;
  logic            r_on;
  logic [3:0]      r_chan;
  logic [6:0]      r_note;
  logic [6:0]      r_vel;
  logic            r_overrun;

  // Two-flop synchronizer. It resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= usart;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx = r_sync2;

  assign w_half = (r_timer == HALF_LAST);
  assign w_full = (r_timer == BIT_LAST);

  // Receive FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Receive FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx) w_next = S_START;
      S_START: if (w_half) w_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_full && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_full) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Receive FSM: outputs and strobes
  always_comb begin
    busy       = (r_state != S_IDLE);
    w_shift    = (r_state == S_DATA) && w_full;
    w_stop_ok  = (r_state == S_STOP) && w_full && w_rx;
    w_stop_bad = (r_state == S_STOP) && w_full && !w_rx;
  end

  // Bit timer, bit index and shift register. The timer restarts on every
  // state change and on every data sample, so it never wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_done <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if ((r_state != w_next) || w_shift) r_timer <= '0;
      else if (r_state != S_IDLE)         r_timer <= r_timer + 1'b1;

      if ((r_state == S_START) && (w_next == S_DATA)) r_bit_idx <= '0;
      else if (w_shift) begin
        if (r_bit_idx == 3'd7) r_bit_idx <= '0;
        else                   r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (w_shift) r_shift <= {w_rx, r_shift[7:1]};

      r_byte_done <= w_stop_ok;
      if (w_stop_ok) r_byte <= r_shift;
      r_frame_err <= w_stop_bad;
    end
  end

`ifdef MIDI_CHAN_FILTER_EN
  assign w_chan_ok = (r_rs_chan == chan_sel);
`else
  assign w_chan_ok = 1'b1;
`endif

  // Message parser. It runs once per received byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_valid <= 1'b0;
      r_rs_note  <= 1'b0;
      r_rs_on    <= 1'b0;
      r_rs_chan  <= '0;
      r_rs_two   <= 1'b0;
      r_dcnt     <= 1'b0;
      r_note_lat <= '0;
      r_evt_done <= 1'b0;
      r_ev_on    <= 1'b0;
      r_ev_chan  <= '0;
      r_ev_note  <= '0;
      r_ev_vel   <= '0;
    end else begin
      r_evt_done <= 1'b0;
      if (r_byte_done) begin
        if (r_byte[7]) begin
          if (r_byte[7:3] == 5'b11111) begin
            // Real-time byte: it leaves the parse state untouched.
          end else if (r_byte[7:4] == 4'hF) begin
            r_rs_valid <= 1'b0;
            r_dcnt     <= 1'b0;
          end else begin
            r_rs_valid <= 1'b1;
            r_rs_note  <= (r_byte[7:5] == 3'b100);
            r_rs_on    <= r_byte[4];
            r_rs_chan  <= r_byte[3:0];
            r_rs_two   <= !((r_byte[7:4] == 4'hC) || (r_byte[7:4] == 4'hD));
            r_dcnt     <= 1'b0;
          end
        end else if (r_rs_valid) begin
          if (!r_dcnt) begin
            // One-byte "other" messages never advance the count.
            r_dcnt     <= r_rs_two;
            r_note_lat <= r_byte[6:0];
          end else begin
            r_dcnt <= 1'b0;
            if (r_rs_note && w_chan_ok) begin
              r_evt_done <= 1'b1;
              r_ev_on    <= r_rs_on && (r_byte[6:0] != 7'd0);
              r_ev_chan  <= r_rs_chan;
              r_ev_note  <= r_note_lat;
              r_ev_vel   <= r_byte[6:0];
            end
          end
        end
      end
    end
  end

  // Single-entry output buffer. A handshake and a new load can happen on
  // the same edge; in that case evt_valid stays high with the new fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_on      <= 1'b0;
      r_chan    <= '0;
      r_note    <= '0;
      r_vel     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_evt_done) begin
        if (!r_valid || evt_ready) begin
          r_valid <= 1'b1;
          r_on    <= r_ev_on;
          r_chan  <= r_ev_chan;
          r_note  <= r_ev_note;
          r_vel   <= r_ev_vel;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && evt_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_on    = r_on;
  assign evt_chan  = r_chan;
  assign evt_note  = r_note;
  assign evt_vel   = r_vel;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_midi_rx_sequencer.sv
// Testbench for midi_rx_sequencer with CLKS_PER_BIT = 16.
// Expected events come from a byte-level model of the MIDI message rules.
module tb_midi_rx_sequencer;
  localparam int unsigned CPB = 16;
  // Stop-bit sample edge, counted from the first rising edge after the start
  // bit begins: 2 synchronizer edges, 1 detect edge, half a bit, 9 full bits.
  localparam int unsigned STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usart = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_on, frame_err, overrun, busy;
  logic [3:0] evt_chan;
  logic [6:0] evt_note, evt_vel;

  always #5 clk = ~clk;

  midi_rx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .usart(usart),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_on(evt_on), .evt_chan(evt_chan), .evt_note(evt_note),
    .evt_vel(evt_vel), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  typedef struct packed {
    logic       on;
    logic [3:0] chan;
    logic [6:0] note;
    logic [6:0] vel;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0, start_cyc = 0, rise_cyc = 0, fe_cyc = 0;
  int unsigned fe_cnt = 0, ov_cnt = 0;
  logic busy_seen = 1'b0, prev_v = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: it samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) got_q.push_back(ev_t'({evt_on, evt_chan, evt_note, evt_vel}));
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (overrun) ov_cnt++;
    if (busy) busy_seen = 1'b1;
    if (evt_valid && !prev_v) rise_cyc = cyc;
    prev_v = evt_valid;
  end

  // Reference model: m_stat < 0 means there is no running status.
  int m_stat = -1, m_cnt = 0, m_note = 0;

  function automatic int msg_len(input int stat);
    return ((stat / 16 == 12) || (stat / 16 == 13)) ? 1 : 2;
  endfunction

  function automatic void model_byte(input int b);
    ev_t e;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin m_stat = -1; m_cnt = 0; return; end
    if (b >= 'h80) begin m_stat = b; m_cnt = 0; return; end
    if (m_stat < 0) return;
    m_cnt++;
    if (m_cnt == msg_len(m_stat)) begin
      m_cnt = 0;
      if (m_stat < 'hA0) begin
        e.on   = (m_stat >= 'h90) && (b != 0);
        e.chan = 4'(m_stat % 16);
        e.note = 7'(m_note);
        e.vel  = 7'(b);
        exp_q.push_back(e);
      end
    end else begin
      m_note = b;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame, starting on a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] v;
    v = b;
    start_cyc = cyc;
    usart = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      usart = v[i];
      tick(CPB);
    end
    usart = stop_bit;
    tick(CPB);
    usart = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(int'(b));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    usart = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    m_stat = -1;
    m_cnt  = 0;
  endtask

  task automatic compare_events(input string tag);
    int unsigned n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, "_on"},   32'(got_q[i].on),   32'(exp_q[i].on));
      chk({tag, "_chan"}, 32'(got_q[i].chan), 32'(exp_q[i].chan));
      chk({tag, "_note"}, 32'(got_q[i].note), 32'(exp_q[i].note));
      chk({tag, "_vel"},  32'(got_q[i].vel),  32'(exp_q[i].vel));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned fe0, ov0;
    logic [7:0] st, n1, v1, n2, v2;
    ev_t held;

    // Reset state
    tick(2);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_fields", 32'({evt_on, evt_chan, evt_note, evt_vel}), 0);
    chk("rst_pulses", 32'({frame_err, overrun}), 0);
    chk("rst_busy", 32'(busy), 0);
    do_reset();
    evt_ready = 1'b1;

    // Basic note-on, including the evt_valid latency
    send(8'h93); send(8'h3C); send(8'h64);
    tick(8);
    chk("lat_valid_rise", rise_cyc - start_cyc, STOP_EDGE + 2);
    compare_events("basic");

    // Running status with a velocity-0 note-off
    send(8'h90); send(8'h40); send(8'h50); send(8'h41); send(8'h00);
    tick(8);
    compare_events("running");

    // Real-time byte inside a message, then a program change that produces
    // no events
    send(8'h90); send(8'h40); send(8'hF8); send(8'h50);
    send(8'hC0); send(8'h05); send(8'h40); send(8'h50);
    tick(8);
    compare_events("realtime_other");

    // Randomized messages with random gaps, running status and real-time bytes
    for (int k = 0; k < 8; k++) begin
      st = ($urandom_range(0, 1) == 1) ? 8'h90 : 8'h80;
      st[3:0] = 4'($urandom_range(0, 15));
      send(st);
      tick($urandom_range(0, 6));
      send(8'($urandom_range(0, 127)));
      if ($urandom_range(0, 3) == 0) send(8'hF8);
      send(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127)));
      if ($urandom_range(0, 1) == 1) begin
        send(8'($urandom_range(0, 127)));
        send(8'($urandom_range(0, 127)));
      end
      tick($urandom_range(0, 6));
    end
    tick(8);
    compare_events("random");

    // Framing error: status is discarded, so later data has no running status
    send(8'hF0);
    fe0 = fe_cnt;
    send_byte(8'h90, 1'b0);
    tick(40);
    chk("fe_count", fe_cnt - fe0, 1);
    chk("fe_timing", fe_cyc - start_cyc, STOP_EDGE);
    send(8'h3C); send(8'h64);
    tick(8);
    compare_events("after_fe");
    chk("fe_busy_idle", 32'(busy), 0);

    // Short glitch on the line: the start bit is rejected
    fe0 = fe_cnt;
    busy_seen = 1'b0;
    usart = 1'b0;
    tick(4);
    usart = 1'b1;
    tick(30);
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    chk("glitch_busy_idle", 32'(busy), 0);
    chk("glitch_no_fe", fe_cnt - fe0, 0);
    compare_events("glitch");

    // Reset in mid-message and mid-byte: running status is lost
    send(8'h95); send(8'h30);
    usart = 1'b0;
    tick(3 * CPB);
    chk("midbyte_busy", 32'(busy), 1);
    do_reset();
    chk("reset_busy", 32'(busy), 0);
    send(8'h31); send(8'h32);
    tick(8);
    compare_events("after_reset");

    // Overrun: the first event is held and the second is dropped
    evt_ready = 1'b0;
    ov0 = ov_cnt;
    st = 8'h90 | 8'($urandom_range(0, 15));
    n1 = 8'($urandom_range(0, 127)); v1 = 8'($urandom_range(1, 127));
    n2 = 8'($urandom_range(0, 127)); v2 = 8'($urandom_range(1, 127));
    send(st); send(n1); send(v1); send(n2); send(v2);
    tick(10);
    held = exp_q[0];
    chk("ovr_held_valid", 32'(evt_valid), 1);
    chk("ovr_held_fields", 32'({evt_on, evt_chan, evt_note, evt_vel}), 32'(held));
    chk("ovr_pulse_count", ov_cnt - ov0, 1);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_before_hs", 32'(evt_valid), 1);
    @(negedge clk);
    chk("ovr_valid_after_hs", 32'(evt_valid), 0);
    tick(10);
    exp_q.delete();
    exp_q.push_back(held);
    compare_events("overrun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
